// File: rtl/reg_cfg_ctrl.sv
// Byte-stream register configurator: loads six defaults, then applies host write/burst commands.
// Host writes appear one cycle after the data byte; byte_rdy_o is low only while loading defaults.
module reg_cfg_ctrl #(
    parameter logic [7:0] DEF_T0H      = 8'd20,
    parameter logic [7:0] DEF_T0L      = 8'd40,
    parameter logic [7:0] DEF_T1H      = 8'd40,
    parameter logic [7:0] DEF_T1L      = 8'd20,
    parameter logic [7:0] DEF_CHAN_LEN = 8'd64,
    parameter logic [7:0] DEF_CHAN_CNT = 8'd8
) (
    input  logic       clk_i,
    input  logic       rst_i,
    input  logic       frame_start_i,
    input  logic       byte_vld_i,
    input  logic [7:0] byte_data_i,
    output logic       byte_rdy_o,
    output logic       reg_wr_en_o,
    output logic [2:0] reg_wr_addr_o,
    output logic [7:0] reg_wr_data_o,
    output logic       cfg_done_o,
    output logic       err_o
);

    typedef enum logic [2:0] {
        LOAD,
        WAIT_CMD,
        WAIT_DATA,
        BURST,
        DISCARD
    } state_t;

    localparam logic [2:0] LAST_ADDR  = 3'd5;
    localparam logic [3:0] OP_WR      = 4'h1;
    localparam logic [3:0] OP_BURST   = 4'h2;
    localparam logic [3:0] OP_RELOAD  = 4'h3;
    localparam logic [3:0] OP_CLR_ERR = 4'h4;

    state_t     state;
    state_t     state_nxt;
    state_t     dec_state;
    logic [2:0] load_idx;
    logic [2:0] load_idx_nxt;
    logic [2:0] cur_addr;
    logic [2:0] cur_addr_nxt;
    logic       wr_en_nxt;
    logic [2:0] wr_addr_nxt;
    logic [7:0] wr_data_nxt;
    logic       cfg_done_nxt;
    logic       err_nxt;
    logic       byte_acc;
    logic [3:0] opcode;
    logic [2:0] cmd_addr;
    logic [7:0] def_val;

    assign byte_rdy_o = (state != LOAD);
    assign byte_acc   = byte_vld_i && byte_rdy_o;
    assign opcode     = byte_data_i[7:4];
    assign cmd_addr   = byte_data_i[2:0];

    // A frame boundary restarts command decode in the same cycle, so a byte
    // arriving with frame_start_i is treated as that frame's command.
    assign dec_state = (frame_start_i && (state != LOAD)) ? WAIT_CMD : state;

    always_comb begin
        def_val = 8'd0;
        case (load_idx)
            3'd0:    def_val = DEF_T0H;
            3'd1:    def_val = DEF_T0L;
            3'd2:    def_val = DEF_T1H;
            3'd3:    def_val = DEF_T1L;
            3'd4:    def_val = DEF_CHAN_LEN;
            3'd5:    def_val = DEF_CHAN_CNT;
            default: def_val = 8'd0;
        endcase
    end

    always_comb begin
        state_nxt    = dec_state;
        load_idx_nxt = load_idx;
        cur_addr_nxt = cur_addr;
        wr_en_nxt    = 1'b0;
        wr_addr_nxt  = reg_wr_addr_o;
        wr_data_nxt  = reg_wr_data_o;
        cfg_done_nxt = cfg_done_o;
        err_nxt      = err_o;

        case (dec_state)
            LOAD: begin
                // load_idx runs one past the last address so cfg_done_o
                // rises the cycle after the final default write.
                if (load_idx <= LAST_ADDR) begin
                    wr_en_nxt    = 1'b1;
                    wr_addr_nxt  = load_idx;
                    wr_data_nxt  = def_val;
                    load_idx_nxt = load_idx + 3'd1;
                end else begin
                    state_nxt    = WAIT_CMD;
                    cfg_done_nxt = 1'b1;
                end
            end

            WAIT_CMD: begin
                if (byte_acc) begin
                    case (opcode)
                        OP_WR, OP_BURST: begin
                            if (cmd_addr <= LAST_ADDR) begin
                                cur_addr_nxt = cmd_addr;
                                state_nxt    = (opcode == OP_WR) ? WAIT_DATA : BURST;
                            end else begin
                                err_nxt   = 1'b1;
                                state_nxt = DISCARD;
                            end
                        end
                        OP_RELOAD: begin
                            state_nxt    = LOAD;
                            load_idx_nxt = 3'd0;
                            cfg_done_nxt = 1'b0;
                        end
                        OP_CLR_ERR: begin
                            err_nxt = 1'b0;
                        end
                        default: begin
                            err_nxt   = 1'b1;
                            state_nxt = DISCARD;
                        end
                    endcase
                end
            end

            WAIT_DATA: begin
                if (byte_acc) begin
                    wr_en_nxt   = 1'b1;
                    wr_addr_nxt = cur_addr;
                    wr_data_nxt = byte_data_i;
                    state_nxt   = WAIT_CMD;
                end
            end

            BURST: begin
                // cur_addr steps past 5 after the last legal write; a byte
                // arriving then is an overrun, never a wrap to address 0.
                if (byte_acc) begin
                    if (cur_addr <= LAST_ADDR) begin
                        wr_en_nxt    = 1'b1;
                        wr_addr_nxt  = cur_addr;
                        wr_data_nxt  = byte_data_i;
                        cur_addr_nxt = cur_addr + 3'd1;
                    end else begin
                        err_nxt   = 1'b1;
                        state_nxt = DISCARD;
                    end
                end
            end

            DISCARD: begin
                state_nxt = DISCARD;
            end

            default: begin
                state_nxt    = LOAD;
                load_idx_nxt = 3'd0;
            end
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state         <= LOAD;
            load_idx      <= 3'd0;
            cur_addr      <= 3'd0;
            reg_wr_en_o   <= 1'b0;
            reg_wr_addr_o <= 3'd0;
            reg_wr_data_o <= 8'd0;
            cfg_done_o    <= 1'b0;
            err_o         <= 1'b0;
        end else begin
            state         <= state_nxt;
            load_idx      <= load_idx_nxt;
            cur_addr      <= cur_addr_nxt;
            reg_wr_en_o   <= wr_en_nxt;
            reg_wr_addr_o <= wr_addr_nxt;
            reg_wr_data_o <= wr_data_nxt;
            cfg_done_o    <= cfg_done_nxt;
            err_o         <= err_nxt;
        end
    end

endmodule

// File: tb/tb_reg_cfg_ctrl.sv
// Scoreboard bench for reg_cfg_ctrl: expected writes queued with their due cycle, checked by a write monitor.
module tb_reg_cfg_ctrl;

    logic       clk_i = 1'b0;
    logic       rst_i;
    logic       frame_start_i;
    logic       byte_vld_i;
    logic [7:0] byte_data_i;
    logic       byte_rdy_o;
    logic       reg_wr_en_o;
    logic [2:0] reg_wr_addr_o;
    logic [7:0] reg_wr_data_o;
    logic       cfg_done_o;
    logic       err_o;

    reg_cfg_ctrl dut (
        .clk_i         (clk_i),
        .rst_i         (rst_i),
        .frame_start_i (frame_start_i),
        .byte_vld_i    (byte_vld_i),
        .byte_data_i   (byte_data_i),
        .byte_rdy_o    (byte_rdy_o),
        .reg_wr_en_o   (reg_wr_en_o),
        .reg_wr_addr_o (reg_wr_addr_o),
        .reg_wr_data_o (reg_wr_data_o),
        .cfg_done_o    (cfg_done_o),
        .err_o         (err_o)
    );

    always #5 clk_i = ~clk_i;

    int unsigned cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    typedef struct {
        int unsigned cyc;
        logic [2:0]  addr;
        logic [7:0]  data;
    } wr_t;

    wr_t sb_q[$];
    int  n_vec = 0;
    int  n_err = 0;
    logic [7:0] defs [6] = '{8'd20, 8'd40, 8'd40, 8'd20, 8'd64, 8'd8};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    task automatic drive(input logic fs, input logic vld, input logic [7:0] d);
        frame_start_i = fs;
        byte_vld_i    = vld;
        byte_data_i   = d;
        tick();
        frame_start_i = 1'b0;
        byte_vld_i    = 1'b0;
    endtask

    task automatic send(input logic fs, input logic [7:0] d);
        check("byte_rdy", {31'd0, byte_rdy_o}, 32'd1);
        drive(fs, 1'b1, d);
    endtask

    task automatic push_wr(input int unsigned dly, input logic [2:0] a, input logic [7:0] d);
        wr_t e;
        e.cyc  = cyc + dly;
        e.addr = a;
        e.data = d;
        sb_q.push_back(e);
    endtask

    task automatic expect_load(input int unsigned first_dly);
        for (int k = 0; k < 6; k++) begin
            logic [2:0] a;
            a = k[2:0];
            push_wr(first_dly + k, a, defs[k]);
        end
    endtask

    task automatic finish_load(input int n_pre);
        for (int k = 0; k < n_pre; k++) begin
            tick();
            check("load_rdy", {31'd0, byte_rdy_o}, 32'd0);
            check("load_done", {31'd0, cfg_done_o}, 32'd0);
        end
        tick();
        check("cfg_done", {31'd0, cfg_done_o}, 32'd1);
        check("post_load_rdy", {31'd0, byte_rdy_o}, 32'd1);
    endtask

    // Write monitor: every strobe must match the oldest queued expectation, on its due cycle.
    always @(negedge clk_i) begin
        if (reg_wr_en_o === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("wr_unexpected", {31'd0, reg_wr_en_o}, 32'd0);
            end else begin
                wr_t e;
                e = sb_q.pop_front();
                check("wr_cycle", cyc, e.cyc);
                check("wr_addr", {29'd0, reg_wr_addr_o}, {29'd0, e.addr});
                check("wr_data", {24'd0, reg_wr_data_o}, {24'd0, e.data});
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_i         = 1'b1;
        frame_start_i = 1'b0;
        byte_vld_i    = 1'b0;
        byte_data_i   = 8'd0;
        tick();
        tick();
        check("rst_wr_en", {31'd0, reg_wr_en_o}, 32'd0);
        check("rst_wr_addr", {29'd0, reg_wr_addr_o}, 32'd0);
        check("rst_wr_data", {24'd0, reg_wr_data_o}, 32'd0);
        check("rst_rdy", {31'd0, byte_rdy_o}, 32'd0);
        check("rst_done", {31'd0, cfg_done_o}, 32'd0);
        check("rst_err", {31'd0, err_o}, 32'd0);

        // Default load after reset release
        rst_i = 1'b0;
        expect_load(1);
        finish_load(6);

        // Single write to address 3
        drive(1'b1, 1'b0, 8'h00);
        send(1'b0, 8'h13);
        push_wr(1, 3'd3, 8'hAA);
        send(1'b0, 8'hAA);
        tick();
        check("single_err", {31'd0, err_o}, 32'd0);

        // Burst from 4 with frame_start on the command byte; overrun dropped
        send(1'b1, 8'h24);
        push_wr(1, 3'd4, 8'h11);
        send(1'b0, 8'h11);
        drive(1'b0, 1'b0, 8'h00);
        push_wr(1, 3'd5, 8'h22);
        send(1'b0, 8'h22);
        check("burst_err_pre", {31'd0, err_o}, 32'd0);
        send(1'b0, 8'h33);
        check("burst_overrun_err", {31'd0, err_o}, 32'd1);
        send(1'b0, 8'h13);
        send(1'b0, 8'h55);
        tick();
        check("discard_err", {31'd0, err_o}, 32'd1);

        // Error clear, bad address, sticky error
        send(1'b1, 8'h40);
        check("clr_err", {31'd0, err_o}, 32'd0);
        send(1'b1, 8'h17);
        check("bad_addr_err", {31'd0, err_o}, 32'd1);
        send(1'b0, 8'h55);
        check("bad_addr_discard", {31'd0, err_o}, 32'd1);
        send(1'b1, 8'h40);
        check("clr_err2", {31'd0, err_o}, 32'd0);
        send(1'b1, 8'h50);
        check("bad_op_err", {31'd0, err_o}, 32'd1);
        send(1'b1, 8'h26);
        check("sticky_err", {31'd0, err_o}, 32'd1);
        send(1'b1, 8'h40);
        check("clr_err3", {31'd0, err_o}, 32'd0);

        // cmd bit 3 is not part of the address: 0x1D targets address 5
        send(1'b1, 8'h1D);
        push_wr(1, 3'd5, 8'hC3);
        send(1'b0, 8'hC3);
        check("addr5_err", {31'd0, err_o}, 32'd0);

        // Full burst 0..5, seventh byte overruns
        send(1'b1, 8'h20);
        for (int k = 0; k < 6; k++) begin
            logic [2:0] a;
            logic [7:0] d;
            a = k[2:0];
            d = 8'hA0 + 8'(k);
            push_wr(1, a, d);
            send(1'b0, d);
        end
        check("full_burst_err", {31'd0, err_o}, 32'd0);
        send(1'b0, 8'hEE);
        check("full_burst_overrun", {31'd0, err_o}, 32'd1);
        send(1'b1, 8'h40);

        // Reload defaults; traffic during LOAD is ignored
        expect_load(2);
        send(1'b1, 8'h30);
        check("reload_done", {31'd0, cfg_done_o}, 32'd0);
        check("reload_rdy", {31'd0, byte_rdy_o}, 32'd0);
        drive(1'b1, 1'b1, 8'h13);
        finish_load(5);
        send(1'b0, 8'h12);
        push_wr(1, 3'd2, 8'h5A);
        send(1'b0, 8'h5A);

        // Reset while waiting for data abandons the write
        send(1'b1, 8'h11);
        rst_i       = 1'b1;
        byte_vld_i  = 1'b1;
        byte_data_i = 8'h99;
        tick();
        rst_i      = 1'b0;
        byte_vld_i = 1'b0;
        check("midrst_wr_en", {31'd0, reg_wr_en_o}, 32'd0);
        check("midrst_done", {31'd0, cfg_done_o}, 32'd0);
        check("midrst_rdy", {31'd0, byte_rdy_o}, 32'd0);
        expect_load(1);
        finish_load(6);

        send(1'b1, 8'h11);
        push_wr(1, 3'd1, 8'h77);
        send(1'b0, 8'h77);
        tick();
        tick();
        tick();
        check("sb_empty", sb_q.size(), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reg_cfg_ctrl.md
REG_CFG_CTRL -- requirements
Module: reg_cfg_ctrl

Interface
REQ-001 SHALL have parameter DEF_T0H, default 8'd20, the register 0 value written by the default load.
REQ-002 SHALL have parameter DEF_T0L, default 8'd40, the register 1 default.
REQ-003 SHALL have parameter DEF_T1H, default 8'd40, the register 2 default.
REQ-004 SHALL have parameter DEF_T1L, default 8'd20, the register 3 default.
REQ-005 SHALL have parameter DEF_CHAN_LEN, default 8'd64, the register 4 default.
REQ-006 SHALL have parameter DEF_CHAN_CNT, default 8'd8, the register 5 default.
REQ-007 SHALL have port clk_i  input  1  the single clock; all logic is on its rising edge.
REQ-008 SHALL have port rst_i  input  1  reset, synchronous and active-high.
REQ-009 SHALL have port frame_start_i  input  1  host frame boundary pulse (CS assertion).
REQ-010 SHALL have port byte_vld_i  input  1  host byte strobe; a byte is accepted when byte_vld_i=1 and byte_rdy_o=1.
REQ-011 SHALL have port byte_data_i  input  8  host byte.
REQ-012 SHALL have port byte_rdy_o  output  1  controller accepts host bytes.
REQ-013 SHALL have port reg_wr_en_o  output  1  register file write strobe.
REQ-014 SHALL have port reg_wr_addr_o  output  3  register file write address (legal range 0..5).
REQ-015 SHALL have port reg_wr_data_o  output  8  register file write data.
REQ-016 SHALL have port cfg_done_o  output  1  default load complete.
REQ-017 SHALL have port err_o  output  1  sticky protocol error flag.

Function
REQ-018 SHALL implement the FSM states LOAD, WAIT_CMD, WAIT_DATA, BURST and DISCARD.
REQ-019 SHALL, in LOAD, write addresses 0..5 with the DEF_* values on 6 consecutive cycles (one write per cycle), then move to WAIT_CMD and set cfg_done_o=1 in the cycle after the last write.
REQ-020 SHALL hold byte_rdy_o=0 in LOAD, and SHALL ignore byte_vld_i and frame_start_i in LOAD.
REQ-021 SHALL hold byte_rdy_o=1 in every state other than LOAD.
REQ-022 SHALL decode the command byte in WAIT_CMD as opcode=cmd[7:4] and addr=cmd[2:0].
REQ-023 SHALL, for opcode 0x1 (single write) with addr<=5, latch addr and move to WAIT_DATA.
REQ-024 SHALL, in WAIT_DATA, write the next accepted byte to the latched addr and return to WAIT_CMD.
REQ-025 SHALL, for opcode 0x2 (burst write) with addr<=5, latch addr and move to BURST.
REQ-026 SHALL, in BURST, write each accepted byte to the current address and then increment the address.
REQ-027 SHALL, in BURST, when the current address is already 5 and another byte arrives, drop that byte, set err_o and move to DISCARD (no wrap-around).
REQ-028 SHALL, for opcode 0x3, clear cfg_done_o and re-enter LOAD on the next cycle.
REQ-029 SHALL, for opcode 0x4, clear err_o and stay in WAIT_CMD.
REQ-030 SHALL, for any other opcode, or for opcode 0x1/0x2 with addr>5, set err_o and move to DISCARD.
REQ-031 SHALL, in DISCARD, drop all bytes until frame_start_i.
REQ-032 SHALL, on frame_start_i outside LOAD, force the state to WAIT_CMD; a byte accepted in the same cycle is decoded as that frame's command byte.
REQ-033 SHALL register host-byte writes so that reg_wr_en_o pulses for exactly 1 cycle, one cycle after the data byte is accepted, with addr and data valid in that same cycle.
REQ-034 SHALL keep reg_wr_en_o=0 in every cycle with no write; reg_wr_addr_o and reg_wr_data_o hold their last values.
REQ-035 SHALL never drive reg_wr_en_o=1 with reg_wr_addr_o>5.
REQ-036 SHALL keep err_o set until opcode 0x4 or reset; a new error while err_o=1 leaves it at 1.

Reset
REQ-037 SHALL, while rst_i=1 at a clock edge, force state=LOAD with load index 0, reg_wr_en_o=0, reg_wr_addr_o=0, reg_wr_data_o=0, byte_rdy_o=0, cfg_done_o=0 and err_o=0.
REQ-038 SHALL, on reset mid-load or mid-frame, abandon the operation and restart the default load from address 0 in the first cycle after rst_i falls.

Verification
REQ-039 SHALL cover: release reset -> writes (0,20),(1,40),(2,40),(3,20),(4,64),(5,8) on 6 consecutive cycles, then cfg_done_o=1 and byte_rdy_o=1.
REQ-040 SHALL cover: frame_start, bytes 0x13 then 0xAA -> one reg_wr_en_o pulse with addr 3 and data 0xAA, one cycle after 0xAA is accepted.
REQ-041 SHALL cover: frame_start, bytes 0x24, 0x11, 0x22, 0x33 -> writes (4,0x11) and (5,0x22); 0x33 is dropped, err_o=1, and later bytes are ignored until the next frame_start.
REQ-042 SHALL cover: byte 0x17, then 0x55, then 0x40 -> no write, err_o=1 after 0x17, err_o=0 after 0x40.
REQ-043 SHALL cover: byte 0x30 -> cfg_done_o=0 and byte_rdy_o=0, the 6 default writes repeat, then cfg_done_o=1.
REQ-044 SHALL cover: rst_i asserted for one cycle during WAIT_DATA after 0x11 -> no write to address 1, and the full default load restarts.
